mult_div_sequencer: RTL
=======================

# mult_div_sequencer

Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from EX, runs a 32-iteration radix-2 shift-add or restoring-divide loop, then writes the HI/LO registers. It also services MFHI/MFLO/MTHI/MTLO and stalls the pipeline while an HI/LO access conflicts with an operation in flight. It sits beside the main ALU, and its read data is muxed into the EX result path.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a valid R-type instruction (ALUOp = 2'b10 qualified upstream).
- funct  in  6  instruction funct field.
- rs_data  in  32  forwarded rs operand (multiplicand / dividend / MTHI/MTLO source).
- rt_data  in  32  forwarded rt operand (multiplier / divisor).
- flush  in  1  EX flush; aborts the in-flight operation.
- stall  out  1  combinational; freezes IF/ID/EX.
- busy  out  1  registered; operation in flight.
- done  out  1  registered; 1-cycle pulse in the cycle HI/LO are written.
- hi, lo  out  32 each  architectural HI/LO registers.
- mf_data  out  32  combinational; hi for MFHI, lo for MFLO, else 0.

## Operation
- Funct codes:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- States:
  - IDLE → RUN: on issue (ex_valid, md op, not busy, no flush).
  - RUN → FIX: when the counter reaches 31.
  - FIX → IDLE: unconditionally.
- Issue in IDLE:
  - Latch |rs|, |rt| for signed ops, raw operands for unsigned ops.
  - Record sign flags and op type; clear the 5-bit counter.
  - The issuing instruction is not stalled and retires normally.
- RUN, one iteration per cycle:
  - Multiply: 64-bit product register; add multiplicand to the upper half if LSB=1, then shift right.
  - Divide: restoring; shift {rem,quot} left, subtract divisor; keep the result if non-negative and set quot LSB.
- FIX:
  - Signed MULT: 64-bit product negated if the operand signs differ.
  - Signed DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - HI ← upper/remainder, LO ← lower/quotient.
  - done=1; busy drops at the end of the cycle.
- Divide by zero (rt=0, signed or unsigned): LO=0xFFFFFFFF, HI=rs_data as issued; sign fix skipped.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (32-bit truncation, no trap).
- MTHI/MTLO with not busy: hi/lo ← rs_data at the clock edge.
- MFHI/MFLO with not busy: mf_data reflects current hi/lo in the same cycle.
- stall = ex_valid & busy & funct ∈ {MULT*, DIV*, MF*, MT*}; all other instructions proceed during busy.
- flush:
  - Returns the state machine to IDLE at the next edge; HI/LO unchanged; no done pulse.
  - Flush wins over a same-cycle issue, and that issue is dropped.
  - Flush during FIX still completes the HI/LO write; the operation belonged to an already-retired instruction.

## Timing
- Reset (asynchronous assert, synchronous-release expected upstream): state=IDLE, counter=0, busy=0, done=0, hi=lo=0; mf_data=0, stall=0.
- Issue sampled at edge E0.
- RUN covers edges E1..E32; FIX completes at E33.
- busy=1 from after E0 through the cycle ending at E33.
- done=1 in the FIX cycle; new HI/LO are visible after E33.
- Total latency: 33 cycles from issue edge to HI/LO update.
- MFHI/MFLO stalled behind an operation are released the cycle after FIX and read the new value.
- Back-to-back md ops are stalled until busy=0, then issue; minimum spacing is 34 cycles.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

## Test plan
- MULT rs=0xFFFFFFFF, rt=0x00000002 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, done 1 cycle. MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=0x12345678, rt=0 → LO=0xFFFFFFFF, HI=0x12345678; no hang, busy clears at E33.
- MULT 3×5, then MFLO presented at E5 → stall high cycles 5–33, low after; mf_data=0x0000000F on release. An unrelated ADD during busy → stall=0.
- MTLO rs=0xA5A5A5A5 while idle → lo=0xA5A5A5A5 next edge; MFLO same cycle afterward → mf_data=0xA5A5A5A5.
- Flush at E10 of a DIV → busy=0 at E11, HI/LO keep prior values, no done. rst_n low at E20 of a MULT → hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - iterative 32-cycle MULT/DIV sequencer with HI/LO and MF/MT handling
module mult_div_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic        r_is_div, r_neg_res, r_neg_rem, r_div0;

    logic        w_is_md, w_is_mf, w_is_mt, w_issue;
    logic        w_rs_neg, w_rt_neg;
    logic [31:0] w_rs_abs, w_rt_abs;
    logic [32:0] w_sum, w_shrem;
    logic [31:0] w_sub, w_quot, w_rem;
    logic        w_ge;
    logic [63:0] w_mul_next, w_div_next, w_prod;

    assign w_is_md = (funct[5:2] == 4'b0110);
    assign w_is_mf = (funct == F_MFHI) || (funct == F_MFLO);
    assign w_is_mt = (funct == F_MTHI) || (funct == F_MTLO);
    assign w_issue = ex_valid && w_is_md && !busy && !flush;

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_FIX);
    assign stall   = ex_valid && busy && (w_is_md || w_is_mf || w_is_mt);
    assign mf_data = (funct == F_MFHI) ? hi : (funct == F_MFLO) ? lo : 32'd0;

    // funct[0] set means the unsigned variant; signed ops iterate on magnitudes
    assign w_rs_neg = !funct[0] && rs_data[31];
    assign w_rt_neg = !funct[0] && rt_data[31];
    assign w_rs_abs = w_rs_neg ? (32'd0 - rs_data) : rs_data;
    assign w_rt_abs = w_rt_neg ? (32'd0 - rt_data) : rt_data;

    assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_sum, r_acc[31:1]};

    assign w_shrem    = {r_acc[63:32], r_acc[31]};
    assign w_ge       = (w_shrem >= {1'b0, r_b});
    assign w_sub      = w_shrem[31:0] - r_b;
    assign w_div_next = {(w_ge ? w_sub : w_shrem[31:0]), r_acc[30:0], w_ge};

    // Divide-by-zero leaves the raw dividend magnitude as remainder; re-signing it restores rs
    assign w_prod = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quot = (r_neg_res && !r_div0) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_rem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_next = S_RUN;
            S_RUN:   if (flush) w_next = S_IDLE;
                     else if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 5'd0;
            r_acc     <= 64'd0;
            r_b       <= 32'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            if (w_issue) begin
                r_cnt     <= 5'd0;
                r_is_div  <= funct[1];
                r_neg_res <= w_rs_neg ^ w_rt_neg;
                r_neg_rem <= w_rs_neg;
                r_div0    <= (rt_data == 32'd0);
                r_acc     <= funct[1] ? {32'd0, w_rs_abs} : {32'd0, w_rt_abs};
                r_b       <= funct[1] ? w_rt_abs : w_rs_abs;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 5'd1;
                r_acc <= r_is_div ? w_div_next : w_mul_next;
            end
            // FIX commits even under flush: its instruction has already retired
            if (r_state == S_FIX) begin
                hi <= r_is_div ? w_rem  : w_prod[63:32];
                lo <= r_is_div ? w_quot : w_prod[31:0];
            end else if (ex_valid && !busy && !flush) begin
                if (funct == F_MTHI) hi <= rs_data;
                if (funct == F_MTLO) lo <= rs_data;
            end
        end
    end
endmodule
